// File: rtl/pim_seq_pkg.sv
// Shared types and constants for the PIM job sequencer and its CFU command issuer.
package pim_seq_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    LOAD_FETCH = 3'd1,
    LOAD_ISSUE = 3'd2,
    LOAD_WAIT  = 3'd3,
    RUN_ISSUE  = 3'd4,
    RUN_WAIT   = 3'd5,
    RESULT     = 3'd6
  } state_e;

  localparam logic [1:0] FID_READ  = 2'b00;
  localparam logic [1:0] FID_WRITE = 2'b01;
  localparam logic [1:0] FID_MAC   = 2'b10;

  localparam int ROW_W       = 8;
  localparam int AWIDTH_DFLT = 10;
  localparam int ROW_LSB     = AWIDTH_DFLT - ROW_W;

endpackage

// File: rtl/pim_cmd_issuer.sv
// Single-outstanding CFU command/response handshake: holds the command payload
// until accepted, then waits for exactly one response and accumulates rsp_ok.
module pim_cmd_issuer
  import pim_seq_pkg::*;
#(
  parameter int AWIDTH = 10,
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              clr_err,
  input  logic [AWIDTH-1:0] fid_i,
  input  logic [DWIDTH-1:0] data_i,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [AWIDTH-1:0] cmd_fid,
  output logic [DWIDTH-1:0] cmd_data,
  output logic              accept,
  input  logic              rsp_valid,
  output logic              rsp_ready,
  input  logic              rsp_ok,
  output logic              done,
  output logic              err
);

  logic              pending_q, pending_d;
  logic              waiting_q, waiting_d;
  logic [AWIDTH-1:0] fid_q, fid_d;
  logic [DWIDTH-1:0] data_q, data_d;
  logic              err_q, err_d;

  always_comb begin
    pending_d = pending_q;
    waiting_d = waiting_q;
    fid_d     = fid_q;
    data_d    = data_q;
    err_d     = err_q;
    accept    = pending_q & cmd_ready;
    // Responses are only looked at once the command has been accepted.
    done      = waiting_q & rsp_valid;

    if (accept) begin
      pending_d = 1'b0;
      waiting_d = 1'b1;
    end
    if (done) begin
      waiting_d = 1'b0;
      err_d     = err_q | ~rsp_ok;
    end
    if (clr_err) begin
      err_d = 1'b0;
    end
    if (start) begin
      pending_d = 1'b1;
      fid_d     = fid_i;
      data_d    = data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q <= 1'b0;
      waiting_q <= 1'b0;
      fid_q     <= '0;
      data_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      waiting_q <= waiting_d;
      fid_q     <= fid_d;
      data_q    <= data_d;
      err_q     <= err_d;
    end
  end

  assign cmd_valid = pending_q;
  assign cmd_fid   = fid_q;
  assign cmd_data  = data_q;
  assign rsp_ready = waiting_q;
  assign err       = err_q;

endmodule

// File: rtl/pim_job_sequencer.sv
// Job-level PIM controller: loads len weight words into consecutive rows, runs
// steps+DRAIN_STEPS MAC commands, and returns the last MAC response.
module pim_job_sequencer
  import pim_seq_pkg::*;
#(
  parameter int AWIDTH      = 10,
  parameter int DWIDTH      = 32,
  parameter int SWIDTH      = 6,
  parameter int DRAIN_STEPS = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              job_valid,
  output logic              job_ready,
  input  logic [7:0]        job_base,
  input  logic [7:0]        job_len,
  input  logic [SWIDTH-1:0] job_steps,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DWIDTH-1:0] wr_data,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DWIDTH-1:0] res_data,
  output logic              res_err,
  output logic              cfu_cmd_valid,
  input  logic              cfu_cmd_ready,
  output logic [AWIDTH-1:0] cfu_cmd_function_id,
  output logic [DWIDTH-1:0] cfu_cmd_inputs_0,
  output logic [DWIDTH-1:0] cfu_cmd_inputs_1,
  input  logic              cfu_rsp_valid,
  output logic              cfu_rsp_ready,
  input  logic              cfu_rsp_ok,
  input  logic [DWIDTH-1:0] cfu_rsp_data,
  output logic              busy
);

  localparam int RWIDTH = SWIDTH + 2;

  state_e            state_q, state_d;
  logic [7:0]        base_q, base_d;
  logic [7:0]        len_q, len_d;
  logic [SWIDTH-1:0] steps_q, steps_d;
  logic [7:0]        load_cnt_q, load_cnt_d, load_cnt_inc;
  logic [RWIDTH-1:0] run_cnt_q, run_cnt_d, run_cnt_inc, run_total;
  logic [DWIDTH-1:0] res_data_q, res_data_d;

  logic              iss_start, iss_clr, iss_accept, iss_done, iss_err;
  logic [AWIDTH-1:0] iss_fid;
  logic [DWIDTH-1:0] iss_data;

  function automatic logic [AWIDTH-1:0] make_fid(input logic [7:0] row, input logic [1:0] code);
    logic [AWIDTH-1:0] f;
    f = '0;
    f[AWIDTH-1 -: 8] = row;
    f[1:0] = code;
    return f;
  endfunction

  assign load_cnt_inc = load_cnt_q + 8'd1;
  assign run_cnt_inc  = run_cnt_q + RWIDTH'(1);
  assign run_total    = RWIDTH'(steps_q) + RWIDTH'(DRAIN_STEPS);

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    len_d      = len_q;
    steps_d    = steps_q;
    load_cnt_d = load_cnt_q;
    run_cnt_d  = run_cnt_q;
    res_data_d = res_data_q;
    iss_start  = 1'b0;
    iss_clr    = 1'b0;
    iss_fid    = make_fid(8'h00, FID_MAC);
    iss_data   = '0;
    job_ready  = 1'b0;
    wr_ready   = 1'b0;
    res_valid  = 1'b0;

    case (state_q)
      IDLE: begin
        job_ready = 1'b1;
        if (job_valid) begin
          base_d     = job_base;
          len_d      = job_len;
          steps_d    = job_steps;
          load_cnt_d = '0;
          run_cnt_d  = '0;
          iss_clr    = 1'b1;
          if (job_len != 8'd0) begin
            state_d = LOAD_FETCH;
          end else if (job_steps != '0) begin
            iss_start = 1'b1;
            state_d   = RUN_ISSUE;
          end else begin
            res_data_d = '0;
            state_d    = RESULT;
          end
        end
      end
      LOAD_FETCH: begin
        wr_ready = 1'b1;
        if (wr_valid) begin
          // Row address wraps modulo 256 by the 8-bit add.
          iss_start = 1'b1;
          iss_fid   = make_fid(base_q + load_cnt_q, FID_WRITE);
          iss_data  = wr_data;
          state_d   = LOAD_ISSUE;
        end
      end
      LOAD_ISSUE: if (iss_accept) state_d = LOAD_WAIT;
      LOAD_WAIT: begin
        if (iss_done) begin
          load_cnt_d = load_cnt_inc;
          if (load_cnt_inc == len_q) begin
            if (steps_q == '0) begin
              res_data_d = '0;
              state_d    = RESULT;
            end else begin
              iss_start = 1'b1;
              state_d   = RUN_ISSUE;
            end
          end else begin
            state_d = LOAD_FETCH;
          end
        end
      end
      RUN_ISSUE: if (iss_accept) state_d = RUN_WAIT;
      RUN_WAIT: begin
        if (iss_done) begin
          run_cnt_d = run_cnt_inc;
          if (run_cnt_inc == run_total) begin
            res_data_d = cfu_rsp_data;
            state_d    = RESULT;
          end else begin
            iss_start = 1'b1;
            state_d   = RUN_ISSUE;
          end
        end
      end
      RESULT: begin
        res_valid = 1'b1;
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      base_q     <= '0;
      len_q      <= '0;
      steps_q    <= '0;
      load_cnt_q <= '0;
      run_cnt_q  <= '0;
      res_data_q <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      len_q      <= len_d;
      steps_q    <= steps_d;
      load_cnt_q <= load_cnt_d;
      run_cnt_q  <= run_cnt_d;
      res_data_q <= res_data_d;
    end
  end

  pim_cmd_issuer #(
    .AWIDTH (AWIDTH),
    .DWIDTH (DWIDTH)
  ) u_issuer (
    .clk       (clk),
    .reset     (reset),
    .start     (iss_start),
    .clr_err   (iss_clr),
    .fid_i     (iss_fid),
    .data_i    (iss_data),
    .cmd_valid (cfu_cmd_valid),
    .cmd_ready (cfu_cmd_ready),
    .cmd_fid   (cfu_cmd_function_id),
    .cmd_data  (cfu_cmd_inputs_0),
    .accept    (iss_accept),
    .rsp_valid (cfu_rsp_valid),
    .rsp_ready (cfu_rsp_ready),
    .rsp_ok    (cfu_rsp_ok),
    .done      (iss_done),
    .err       (iss_err)
  );

  assign cfu_cmd_inputs_1 = '0;
  assign res_data         = res_data_q;
  assign res_err          = iss_err;
  assign busy             = (state_q != IDLE);

endmodule
